// File: rtl/xor_checksum.sv
// xor_checksum: streaming XOR checksum over a frame of WIDTH-bit words.
//
// Folds every accepted word of a frame into one XOR sum. When the frame closes,
// it reports the sum, the reduction parity of the sum, the word count
// (saturating at MAX_LEN) and an overflow flag. Both sides use valid/ready
// handshakes. A result is held until the consumer takes it, and no input is
// accepted while a result is pending.
//
// Ports
//   clk          clock; all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   flush        synchronous abort of the open frame or the pending result
//   in_valid     in_data / in_last are valid
//   in_ready     unit can accept a word (low in reset and while holding a result)
//   in_data      input word
//   in_last      marks the final word of a frame
//   out_valid    result registers are valid
//   out_ready    consumer takes the result
//   out_sum      XOR of all frame words
//   out_parity   reduction XOR of out_sum
//   out_count    words in frame, saturating at MAX_LEN
//   out_overflow frame had more than MAX_LEN words

module xor_checksum #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned MAX_LEN = 16,
    localparam int unsigned CW     = $clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_parity,
    output logic [CW-1:0]    out_count,
    output logic             out_overflow
);

    localparam logic [CW-1:0] MaxCnt = CW'(MAX_LEN);

    typedef enum logic [1:0] {
        StIdle,
        StAcc,
        StHold
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             out_valid_d;
    logic [WIDTH-1:0] out_sum_d;
    logic             out_parity_d;
    logic [CW-1:0]    out_count_d;
    logic             out_overflow_d;

    // Frame state after folding in the word on in_data this cycle.
    logic [WIDTH-1:0] acc_fold;
    logic [CW-1:0]    cnt_fold;
    logic             ovf_fold;

    logic             accept;

    // in_ready depends on rst_n directly so that it drops the moment reset is asserted.
    assign in_ready = rst_n && (state_q != StHold);
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        acc_fold = in_data;
        cnt_fold = CW'(1);
        ovf_fold = 1'b0;
        if (state_q == StAcc) begin
            acc_fold = acc_q ^ in_data;
            if (cnt_q < MaxCnt) begin
                cnt_fold = cnt_q + CW'(1);
                ovf_fold = ovf_q;
            end else begin
                cnt_fold = cnt_q;
                ovf_fold = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        ovf_d          = ovf_q;
        out_valid_d    = out_valid;
        out_sum_d      = out_sum;
        out_parity_d   = out_parity;
        out_count_d    = out_count;
        out_overflow_d = out_overflow;

        if (flush) begin
            // flush wins over a simultaneous accept or output handshake.
            // The output data registers keep their old values; out_valid marks them stale.
            state_d     = StIdle;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                StIdle, StAcc: begin
                    if (accept) begin
                        if (in_last) begin
                            state_d        = StHold;
                            out_valid_d    = 1'b1;
                            out_sum_d      = acc_fold;
                            out_parity_d   = ^acc_fold;
                            out_count_d    = cnt_fold;
                            out_overflow_d = ovf_fold;
                            acc_d          = '0;
                            cnt_d          = '0;
                            ovf_d          = 1'b0;
                        end else begin
                            state_d = StAcc;
                            acc_d   = acc_fold;
                            cnt_d   = cnt_fold;
                            ovf_d   = ovf_fold;
                        end
                    end
                end
                StHold: begin
                    if (out_valid && out_ready) begin
                        state_d     = StIdle;
                        out_valid_d = 1'b0;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            acc_q        <= '0;
            cnt_q        <= '0;
            ovf_q        <= 1'b0;
            out_valid    <= 1'b0;
            out_sum      <= '0;
            out_parity   <= 1'b0;
            out_count    <= '0;
            out_overflow <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            ovf_q        <= ovf_d;
            out_valid    <= out_valid_d;
            out_sum      <= out_sum_d;
            out_parity   <= out_parity_d;
            out_count    <= out_count_d;
            out_overflow <= out_overflow_d;
        end
    end

endmodule

// File: tb/tb_xor_checksum.sv
// Self-checking bench for xor_checksum (WIDTH=8, MAX_LEN=4). Expected results are
// computed by a behavioural frame model, queued when the last word is accepted,
// and compared when the DUT completes an output handshake.

module tb_xor_checksum;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned MAX_LEN = 4;
    localparam int unsigned CW      = $clog2(MAX_LEN + 1);

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             parity;
        logic [CW-1:0]    count;
        logic             ovf;
    } res_t;

    logic             clk;
    logic             rst_n;
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_parity;
    logic [CW-1:0]    out_count;
    logic             out_overflow;

    xor_checksum #(
        .WIDTH  (WIDTH),
        .MAX_LEN(MAX_LEN)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_sum     (out_sum),
        .out_parity  (out_parity),
        .out_count   (out_count),
        .out_overflow(out_overflow)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int   n_tests = 0;
    int   n_fail  = 0;
    res_t exp_q[$];

    // Frame model.
    logic [WIDTH-1:0] m_acc;
    int               m_cnt;
    logic             m_ovf;
    logic             m_open;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_accept(input logic [WIDTH-1:0] d, input logic last);
        res_t r;
        if (!m_open) begin
            m_acc  = d;
            m_cnt  = 1;
            m_ovf  = 1'b0;
            m_open = 1'b1;
        end else begin
            m_acc = m_acc ^ d;
            if (m_cnt < int'(MAX_LEN)) m_cnt++;
            else m_ovf = 1'b1;
        end
        if (last) begin
            r.sum    = m_acc;
            r.parity = ^m_acc;
            r.count  = CW'(m_cnt);
            r.ovf    = m_ovf;
            exp_q.push_back(r);
            m_open = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_open = 1'b0;
        exp_q.delete();
    endtask

    // Called at posedge+1; returns at posedge+1 after the word is accepted.
    task automatic send_word(input logic [WIDTH-1:0] d, input logic last, output int waited);
        waited   = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            check_eq("accept_timeout", {31'b0, in_ready}, 32'd1);
        end else begin
            @(posedge clk);
            model_accept(d, last);
            #1;
        end
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    task automatic drain();
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Output monitor: pops on handshake, checks stability while stalled.
    logic             hold_seen;
    logic [WIDTH-1:0] hold_sum;
    logic             hold_par;
    logic [CW-1:0]    hold_cnt;
    logic             hold_ovf;

    initial begin
        res_t r;
        hold_seen = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n || !out_valid) begin
                hold_seen = 1'b0;
            end else begin
                if (hold_seen) begin
                    check_eq("stable_sum", 32'(out_sum), 32'(hold_sum));
                    check_eq("stable_par", 32'(out_parity), 32'(hold_par));
                    check_eq("stable_cnt", 32'(out_count), 32'(hold_cnt));
                    check_eq("stable_ovf", 32'(out_overflow), 32'(hold_ovf));
                end
                if (out_ready) begin
                    hold_seen = 1'b0;
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_out", 32'(out_valid), 32'd0);
                    end else begin
                        r = exp_q.pop_front();
                        check_eq("out_sum", 32'(out_sum), 32'(r.sum));
                        check_eq("out_parity", 32'(out_parity), 32'(r.parity));
                        check_eq("out_count", 32'(out_count), 32'(r.count));
                        check_eq("out_overflow", 32'(out_overflow), 32'(r.ovf));
                    end
                end else begin
                    hold_seen = 1'b1;
                    hold_sum  = out_sum;
                    hold_par  = out_parity;
                    hold_cnt  = out_count;
                    hold_ovf  = out_overflow;
                end
            end
        end
    end

    initial begin
        int w;
        rst_n     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b1;
        m_open    = 1'b0;
        m_acc     = '0;
        m_cnt     = 0;
        m_ovf     = 1'b0;
        idle_in();

        // Reset state.
        #3;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_sum", 32'(out_sum), 32'd0);
        check_eq("rst_out_parity", 32'(out_parity), 32'd0);
        check_eq("rst_out_count", 32'(out_count), 32'd0);
        check_eq("rst_out_overflow", 32'(out_overflow), 32'd0);
        #4;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("rel_in_ready", 32'(in_ready), 32'd1);
        check_eq("rel_out_valid", 32'(out_valid), 32'd0);

        // Basic frame: 0F ^ F0 ^ 55 = AA.
        send_word(8'h0F, 1'b0, w);
        send_word(8'hF0, 1'b0, w);
        send_word(8'h55, 1'b1, w);
        idle_in();
        check_eq("latency_valid", 32'(out_valid), 32'd1);
        drain();

        // Single-word frame.
        send_word(8'h07, 1'b1, w);
        idle_in();
        drain();

        // Backpressure: result stalls for 3 cycles with a word waiting.
        out_ready = 1'b0;
        send_word(8'h0F, 1'b0, w);
        send_word(8'hF0, 1'b0, w);
        send_word(8'h55, 1'b1, w);
        in_valid = 1'b1;
        in_data  = 8'h11;
        in_last  = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_eq("bp_in_ready", 32'(in_ready), 32'd0);
            check_eq("bp_out_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_word(8'h11, 1'b1, w);
        check_eq("bp_accept_wait", 32'(w), 32'd1);
        idle_in();
        drain();

        // Overflow: 6 words into a 4-word limit.
        for (int i = 0; i < 6; i++) send_word(8'h01, (i == 5), w);
        idle_in();
        drain();

        // Flush mid-frame; the word presented with flush is dropped.
        send_word(8'hAA, 1'b0, w);
        send_word(8'hBB, 1'b0, w);
        in_valid = 1'b1;
        in_data  = 8'hCC;
        in_last  = 1'b0;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush  = 1'b0;
        m_open = 1'b0;
        idle_in();
        send_word(8'h3C, 1'b1, w);
        idle_in();
        drain();

        // Reset pulse mid-frame.
        send_word(8'hAA, 1'b0, w);
        send_word(8'hBB, 1'b0, w);
        idle_in();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("mid_rst_out_valid", 32'(out_valid), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send_word(8'h3C, 1'b1, w);
        idle_in();
        drain();

        // Reset while a result is pending.
        out_ready = 1'b0;
        send_word(8'h5A, 1'b1, w);
        idle_in();
        check_eq("hold_valid", 32'(out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("hold_rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("hold_rst_valid", 32'(out_valid), 32'd0);
        check_eq("hold_rst_sum", 32'(out_sum), 32'd0);
        check_eq("hold_rst_parity", 32'(out_parity), 32'd0);
        check_eq("hold_rst_count", 32'(out_count), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);
        send_word(8'h80, 1'b1, w);
        idle_in();
        drain();

        check_eq("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
